seq_bit_serializer: RTL and testbench

- Parallel-in, serial-out stage that sits directly upstream of the serial pattern detector and drives its one-bit-per-clock `datain` input.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock.
- A one-word holding register keeps back-to-back words gapless, so patterns that span word boundaries are seen by the detector.
- Outside a word, the serial output sits at a fixed idle level.

---
 rtl/seq_bit_serializer.sv | 122 ++++++++++++
 tb/tb_seq_bit_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-in, serial-out word serializer with a one-word holding register.
// Emits one bit per clock, gapless across back-to-back words, idle level otherwise.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dataout,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [15:0]      tx_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [WIDTH-1:0] hold, hold_nx;
  logic             hold_full, hold_full_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             dout_nx, bv_nx, fs_nx, tx_inc;
  logic             accept;

  // The bit on dataout always sits at the head end of sreg.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign din_ready = !hold_full && !rst;
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_nx     = state;
    sreg_nx      = sreg;
    hold_nx      = hold;
    hold_full_nx = hold_full;
    cnt_nx       = cnt;
    bv_nx        = 1'b0;
    fs_nx        = 1'b0;
    tx_inc       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sreg_nx  = din;
          cnt_nx   = '0;
          state_nx = SHIFT;
          bv_nx    = 1'b1;
          fs_nx    = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          tx_inc = 1'b1;
          cnt_nx = '0;
          // A held word has priority; din_ready is low then, so no accept can collide.
          if (hold_full) begin
            sreg_nx      = hold;
            hold_full_nx = 1'b0;
            bv_nx        = 1'b1;
            fs_nx        = 1'b1;
          end else if (accept) begin
            sreg_nx = din;
            bv_nx   = 1'b1;
            fs_nx   = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          sreg_nx = advance(sreg);
          cnt_nx  = cnt + CW'(1);
          bv_nx   = 1'b1;
          if (accept) begin
            hold_nx      = din;
            hold_full_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    dout_nx = bv_nx ? head_bit(sreg_nx) : IDLE_BIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sreg        <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      cnt         <= '0;
      dataout     <= IDLE_BIT;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      tx_count    <= 16'h0000;
    end else begin
      state       <= state_nx;
      sreg        <= sreg_nx;
      hold        <= hold_nx;
      hold_full   <= hold_full_nx;
      cnt         <= cnt_nx;
      dataout     <= dout_nx;
      bit_valid   <= bv_nx;
      frame_start <= fs_nx;
      busy        <= (state_nx == SHIFT) || hold_full_nx;
      tx_count    <= tx_count + 16'(tx_inc);
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Randomized scoreboard bench for seq_bit_serializer: accepted words become a queue
// of expected serial bits that a negedge monitor pops while checking the outputs.
module tb_seq_bit_serializer;

  localparam int W        = 8;
  localparam bit IDLE_LVL = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          din_ready, dataout, bit_valid, frame_start, busy;
  logic [15:0]   tx_count;

  logic          l_rst;
  logic [W-1:0]  l_din;
  logic          l_valid;
  logic          l_ready, l_dataout, l_bit_valid, l_frame_start, l_busy;
  logic [15:0]   l_tx_count;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_LVL)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dataout(dataout), .bit_valid(bit_valid), .frame_start(frame_start),
    .busy(busy), .tx_count(tx_count)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_LVL)) dut_lsb (
    .clk(clk), .rst(l_rst), .din(l_din), .din_valid(l_valid), .din_ready(l_ready),
    .dataout(l_dataout), .bit_valid(l_bit_valid), .frame_start(l_frame_start),
    .busy(l_busy), .tx_count(l_tx_count)
  );

  typedef struct {
    bit b;
    bit fs;
    bit last;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          accept_allowed = 1'b0;
  bit          lsb_done = 1'b0;
  logic [15:0] model_done = 16'h0000;
  int          n;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: every accepted word appends its bits in transmit order.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      model_done = 16'h0000;
    end else if (din_valid && accept_allowed) begin
      for (int i = 0; i < W; i++) begin
        exp_t e;
        e.b    = din[W-1-i];
        e.fs   = (i == 0);
        e.last = (i == W - 1);
        q.push_back(e);
      end
    end
  end

  // The queue head is the bit on the wire; more than one word queued means hold is full.
  always @(negedge clk) begin
    if (mon_en) begin
      n = q.size();
      checkOutput("din_ready", {31'b0, din_ready}, {31'b0, (!rst && n <= W)});
      checkOutput("busy", {31'b0, busy}, {31'b0, (n > 0)});
      checkOutput("bit_valid", {31'b0, bit_valid}, {31'b0, (n > 0)});
      if (n > 0) begin
        checkOutput("dataout", {31'b0, dataout}, {31'b0, q[0].b});
        checkOutput("frame_start", {31'b0, frame_start}, {31'b0, q[0].fs});
      end else begin
        checkOutput("dataout_idle", {31'b0, dataout}, {31'b0, IDLE_LVL});
        checkOutput("frame_start_idle", {31'b0, frame_start}, 32'd0);
      end
      checkOutput("tx_count", {16'b0, tx_count}, {16'b0, model_done});
      accept_allowed = !rst && n <= W;
      if (n > 0) begin
        if (q[0].last) model_done++;
        void'(q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] word);
    bit ok;
    ok = 1'b0;
    din = word;
    din_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("[TB] FAIL accept_timeout at %0t: got din_ready=0 expected 1 within 200 cycles", $time);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din = W'($urandom);
  endtask

  task automatic idleCycles(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic pulseReset(input int cyc);
    rst = 1'b1;
    din_valid = 1'b1;
    din = W'($urandom);
    idleCycles(cyc);
    rst = 1'b0;
    din_valid = 1'b0;
  endtask

  // LSB-first instance: 8'h01 must leave as a single leading 1.
  initial begin
    l_rst = 1'b1;
    l_valid = 1'b0;
    l_din = '0;
    repeat (2) @(posedge clk);
    #1;
    l_rst = 1'b0;
    l_din = 8'h01;
    l_valid = 1'b1;
    @(negedge clk);
    checkOutput("lsb_ready", {31'b0, l_ready}, 32'd1);
    @(posedge clk);
    #1;
    l_valid = 1'b0;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      checkOutput("lsb_dataout", {31'b0, l_dataout}, (i == 1) ? 32'd1 : 32'd0);
      checkOutput("lsb_bit_valid", {31'b0, l_bit_valid}, 32'd1);
      checkOutput("lsb_frame_start", {31'b0, l_frame_start}, (i == 1) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    checkOutput("lsb_idle_dataout", {31'b0, l_dataout}, {31'b0, IDLE_LVL});
    checkOutput("lsb_idle_valid", {31'b0, l_bit_valid}, 32'd0);
    checkOutput("lsb_tx_count", {16'b0, l_tx_count}, 32'd1);
    lsb_done = 1'b1;
  end

  initial begin
    bit drained;
    rst = 1'b1;
    din_valid = 1'b0;
    din = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    idleCycles(2);

    // Reset lands mid-word; the word offered during reset is dropped.
    applyStimulus(8'hFF);
    idleCycles(2);
    pulseReset(1);
    idleCycles(3);

    applyStimulus(8'hB5);
    idleCycles(12);

    applyStimulus(8'hB5);
    applyStimulus(8'h5A);
    idleCycles(20);

    applyStimulus(8'h0B);
    applyStimulus(8'h50);
    idleCycles(20);

    applyStimulus(8'h0B);
    idleCycles(9);
    applyStimulus(8'h50);
    idleCycles(12);

    for (int k = 0; k < 400; k++) begin
      applyStimulus(W'($urandom));
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 10));
      if ($urandom_range(0, 59) == 0) pulseReset($urandom_range(1, 2));
    end

    drained = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) begin
      errors++;
      $display("[TB] FAIL drain_timeout at %0t: got %0d queued bits expected 0", $time, q.size());
    end
    idleCycles(4);
    for (int i = 0; i < 100 && !lsb_done; i++) @(posedge clk);
    if (!lsb_done) begin
      errors++;
      $display("[TB] FAIL lsb_timeout at %0t: got lsb_done=0 expected 1", $time);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
